// File: rtl/hazard_unit.sv
// Pipeline hazard unit: load-use and branch-operand stall detection, IF/ID flush on redirect.
// Optional performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module hazard_unit (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [4:0]  IF_ID_Rs,
  input  logic [4:0]  IF_ID_Rt,
  input  logic        ID_UsesRt,
  input  logic        ID_Branch,
  input  logic        ID_Redirect,
  input  logic [1:0]  ID_EX_MemRead,
  input  logic        ID_EX_RegWrite,
  input  logic [4:0]  ID_EX_Dest,
  input  logic [1:0]  EX_MEM_MemRead,
  input  logic [4:0]  EX_MEM_Dest,
  output logic        controlMuxSignal,
  output logic        PCWrite,
  output logic        IF_ID_Write,
  output logic        IF_ID_Flush,
  output logic [15:0] StallCnt,
  output logic [15:0] FlushCnt
);

  typedef enum logic {RUN, STALL} state_t;

  state_t     state, state_nxt;
  logic [1:0] remain, remain_nxt;
  logic [1:0] need;
  logic       stall;

  logic ex_load, mem_load, ex_match, mem_match;
  logic ld_use, br_alu, br_ld, br_mem;

  // $0 never creates a dependency; Rt only counts when the ID instruction reads it.
  always_comb begin
    ex_load   = (ID_EX_MemRead != 2'b00);
    mem_load  = (EX_MEM_MemRead != 2'b00);
    ex_match  = ((IF_ID_Rs != 5'd0) && (IF_ID_Rs == ID_EX_Dest)) ||
                (ID_UsesRt && (IF_ID_Rt != 5'd0) && (IF_ID_Rt == ID_EX_Dest));
    mem_match = ((IF_ID_Rs != 5'd0) && (IF_ID_Rs == EX_MEM_Dest)) ||
                (ID_UsesRt && (IF_ID_Rt != 5'd0) && (IF_ID_Rt == EX_MEM_Dest));
    ld_use    = ex_load && ex_match;
    br_alu    = ID_Branch && ID_EX_RegWrite && !ex_load && ex_match;
    br_ld     = ID_Branch && ex_load && ex_match;
    br_mem    = ID_Branch && mem_load && mem_match && !ex_match;
    need      = 2'd0;
    if (ld_use || br_alu || br_mem) need = 2'd1;
    if (br_ld)                      need = 2'd2;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state  <= RUN;
      remain <= 2'd0;
    end else begin
      state  <= state_nxt;
      remain <= remain_nxt;
    end
  end

  // First stall cycle is issued from RUN (Mealy); STALL only covers the extra cycles.
  always_comb begin
    state_nxt  = state;
    remain_nxt = remain;
    stall      = 1'b0;
    case (state)
      RUN: begin
        if (need != 2'd0) begin
          stall = 1'b1;
          if (need == 2'd2) begin
            state_nxt  = STALL;
            remain_nxt = 2'd1;
          end
        end
      end
      STALL: begin
        stall      = 1'b1;
        remain_nxt = (remain == 2'd0) ? 2'd0 : remain - 2'd1;
        state_nxt  = (remain <= 2'd1) ? RUN : STALL;
      end
      default: begin
        state_nxt  = RUN;
        remain_nxt = 2'd0;
      end
    endcase
  end

  // Outputs are forced low while reset is held; stall wins over a redirect flush.
  always_comb begin
    controlMuxSignal = Rst && !stall;
    PCWrite          = Rst && !stall;
    IF_ID_Write      = Rst && !stall;
    IF_ID_Flush      = Rst && ID_Redirect && !stall;
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      StallCnt <= 16'h0000;
      FlushCnt <= 16'h0000;
    end else begin
      if (stall && (StallCnt != 16'hFFFF))       StallCnt <= StallCnt + 16'd1;
      if (IF_ID_Flush && (FlushCnt != 16'hFFFF)) FlushCnt <= FlushCnt + 16'd1;
    end
  end
`else
  assign StallCnt = 16'h0000;
  assign FlushCnt = 16'h0000;
`endif

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Clk  in  1  pipeline clock; all state updates on rising edge.
REQ-002 Rst  in  1  asynchronous, active-low reset; Rst=0 forces reset state immediately.
REQ-003 IF_ID_Rs, IF_ID_Rt  in  5 each  source register fields of the instruction in ID.
REQ-004 ID_UsesRt  in  1  1 = ID instruction reads Rt (R-type, store, beq/bne).
REQ-005 ID_Branch  in  1  1 = ID instruction is a branch or Jr and compares/reads registers in ID.
REQ-006 ID_Redirect  in  1  1 = branch taken, Jump or Jal resolved in ID this cycle.
REQ-007 ID_EX_MemRead  in  2  nonzero = EX-stage instruction is a load.
REQ-008 ID_EX_RegWrite  in  1  EX-stage instruction writes a register.
REQ-009 ID_EX_Dest  in  5  EX-stage destination register after RegDst/Jal selection.
REQ-010 EX_MEM_MemRead  in  2  nonzero = MEM-stage instruction is a load.
REQ-011 EX_MEM_Dest  in  5  MEM-stage destination register.
REQ-012 controlMuxSignal  out  1  1 = pass ID control to ID/EX; 0 = insert bubble (all controls zero).
REQ-013 PCWrite  out  1  1 = PC updates this cycle.
REQ-014 IF_ID_Write  out  1  1 = IF/ID register loads.
REQ-015 IF_ID_Flush  out  1  1 = IF/ID register clears to NOP next edge.
REQ-016 StallCnt, FlushCnt  out  16 each  performance counters (see Configuration).

Function
REQ-017 Hazard match SHALL require source register nonzero; Rt compared only when ID_UsesRt=1.
REQ-018 Load-use: ID_EX_MemRead!=0 and ID_EX_Dest matches a used source -> need=1 stall cycle.
REQ-019 Branch-ALU: ID_Branch=1, ID_EX_RegWrite=1, ID_EX_MemRead=0, ID_EX_Dest matches -> need=1.
REQ-020 Branch-load: ID_Branch=1, ID_EX_MemRead!=0, ID_EX_Dest matches -> need=2.
REQ-021 Branch-load-MEM: ID_Branch=1, EX_MEM_MemRead!=0, EX_MEM_Dest matches, no EX-stage match -> need=1.
REQ-022 Multiple matches SHALL take the maximum need.
REQ-023 FSM states RUN and STALL with 2-bit counter Remain.
REQ-024 RUN, need=0: controlMuxSignal=1, PCWrite=1, IF_ID_Write=1; stay RUN.
REQ-025 RUN, need>=1: stall outputs (controlMuxSignal=0, PCWrite=0, IF_ID_Write=0) same cycle (Mealy); if need=2 go STALL with Remain=1, else stay RUN.
REQ-026 STALL: stall outputs asserted unconditionally; Remain decrements; on Remain=1 return to RUN next edge.
REQ-027 Detection SHALL NOT be re-evaluated while in STALL; first RUN cycle re-evaluates fresh.
REQ-028 IF_ID_Flush=1 iff ID_Redirect=1 and no stall output asserted this cycle; stall has priority (branch operands not ready).
REQ-029 Total stall for load followed by dependent branch SHALL be exactly 2 cycles.

Reset
REQ-030 Rst=0: state RUN, Remain=0, StallCnt=0, FlushCnt=0 asynchronously.
REQ-031 During reset outputs: controlMuxSignal=0, PCWrite=0, IF_ID_Write=0, IF_ID_Flush=0.
REQ-032 Reset asserted mid-STALL SHALL abandon the stall; first cycle after release is RUN.

Configuration
REQ-033 Macro HAZARD_PERF_CNT_EN defined: StallCnt increments each cycle stall outputs asserted, FlushCnt each cycle IF_ID_Flush=1; both saturate at 16'hFFFF.
REQ-034 Macro undefined: StallCnt and FlushCnt ports remain, tied to 16'h0000; no counter logic.

Verification
REQ-035 ID_EX load to $5, ID add reads Rs=$5 -> one cycle controlMuxSignal=0, PCWrite=0, IF_ID_Write=0, then all 1.
REQ-036 ID_EX load to $8, ID beq Rs=$8 -> exactly 2 stall cycles, then beq proceeds; StallCnt=2 with macro.
REQ-037 ID_EX add to $3 (RegWrite=1), ID bne Rt=$3 ID_UsesRt=1 -> exactly 1 stall cycle.
REQ-038 ID_EX load to $0, ID reads $0 -> no stall; ID_Redirect=1 -> IF_ID_Flush=1 one cycle, FlushCnt=1.
REQ-039 Load-branch hazard with ID_Redirect=1 -> IF_ID_Flush=0 during stall; Rst pulsed low in STALL -> outputs zero, RUN after release.
